// File: rtl/mux_scan_ctrl_pkg.sv
// Shared widths and FSM state encoding for the mux scan sequencer.
package mux_scan_pkg;

   localparam int unsigned NUM_CH   = 16;
   localparam int unsigned SEL_W    = 4;
   localparam int unsigned SETTLE_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE
   } scan_state_t;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Mux-select / sample path and frame valid/ready handshake of the scan sequencer.
interface mux_scan_ctrl_if;
   import mux_scan_pkg::*;

   logic [SEL_W-1:0]  sel;
   logic              mux_out;
   logic [NUM_CH-1:0] frame;
   logic              frame_valid;
   logic              frame_ready;

   modport master (
      output sel,
      output frame,
      output frame_valid,
      input  mux_out,
      input  frame_ready
   );

   modport slave (
      input  sel,
      input  frame,
      input  frame_valid,
      output mux_out,
      output frame_ready
   );

endinterface

// File: rtl/mux_16to1.sv
// 16:1 single-bit mux that the scan sequencer drives; the parent instantiates it beside the sequencer.
module mux_16to1 (
   input  logic [15:0] in,
   input  logic [3:0]  sel,
   output logic        out
);

   assign out = in[sel];

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps a 16:1 mux select across all channels, samples each after a settle delay,
// and hands the assembled frame downstream over valid/ready with overrun detection.
module mux_scan_ctrl
   import mux_scan_pkg::*;
#(
   parameter int unsigned SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             continuous,
   input  logic             ovr_clr,
   mux_scan_ctrl_if.master  bus,
   output logic             busy,
   output logic             overrun
);

   localparam logic [SEL_W-1:0]    LAST_SEL = SEL_W'(NUM_CH - 1);
   localparam logic [SETTLE_W-1:0] CNT_LOAD = SETTLE_W'(SETTLE - 1);

   scan_state_t         state_q, state_d;
   logic [SETTLE_W-1:0] cnt_q, cnt_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [NUM_CH-1:0]   acc_q, acc_d;
   logic [NUM_CH-1:0]   frame_q, frame_d;
   logic                fv_q, fv_d;
   logic                busy_q, busy_d;
   logic                ovr_q, ovr_d;
   logic                complete;
   logic                drop;

   // Next-state, datapath and handshake logic
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sel_d    = sel_q;
      acc_d    = acc_q;
      frame_d  = frame_q;
      fv_d     = fv_q;
      complete = 1'b0;
      drop     = 1'b0;

      if (fv_q && bus.frame_ready) begin
         fv_d = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = mux_scan_pkg::SETTLE;
               sel_d   = '0;
               cnt_d   = CNT_LOAD;
               acc_d   = '0;
            end
         end
         mux_scan_pkg::SETTLE: begin
            if (cnt_q == '0) begin
               state_d = SAMPLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         SAMPLE: begin
            acc_d[sel_q] = bus.mux_out;
            if (sel_q != LAST_SEL) begin
               sel_d   = sel_q + 1'b1;
               cnt_d   = CNT_LOAD;
               state_d = mux_scan_pkg::SETTLE;
            end else begin
               complete = 1'b1;
               if (continuous) begin
                  sel_d   = '0;
                  cnt_d   = CNT_LOAD;
                  state_d = mux_scan_pkg::SETTLE;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A finished frame only lands if the output slot is free or being drained this edge
      if (complete) begin
         if (!fv_q || bus.frame_ready) begin
            frame_d = acc_d;
            fv_d    = 1'b1;
         end else begin
            drop = 1'b1;
         end
      end

      ovr_d  = drop | (ovr_q & ~ovr_clr);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sel_q   <= '0;
         acc_q   <= '0;
         frame_q <= '0;
         fv_q    <= 1'b0;
         busy_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         acc_q   <= acc_d;
         frame_q <= frame_d;
         fv_q    <= fv_d;
         busy_q  <= busy_d;
         ovr_q   <= ovr_d;
      end
   end

   assign bus.sel         = sel_q;
   assign bus.frame       = frame_q;
   assign bus.frame_valid = fv_q;
   assign busy            = busy_q;
   assign overrun         = ovr_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: scoreboarded frames on a SETTLE=1 instance,
// cycle-by-cycle select checks on a SETTLE=3 instance, both driven through real muxes.
module tb_mux_scan_ctrl;

   typedef struct {
      logic [15:0] frame;
      int          cyc;
   } exp_t;

   typedef struct {
      logic [15:0] mux_in;
      logic [15:0] exp_frame;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start1 = 1'b0, cont1 = 1'b0, ovr_clr1 = 1'b0;
   logic        start3 = 1'b0, cont3 = 1'b0, ovr_clr3 = 1'b0;
   logic [15:0] in1 = 16'h0000, in3 = 16'h0000;
   logic        busy1, overrun1, busy3, overrun3;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   frames_seen = 0;
   exp_t sb[$];
   logic fv_prev = 1'b0;
   logic rdy_edge = 1'b0;

   mux_scan_ctrl_if if1 ();
   mux_scan_ctrl_if if3 ();

   mux_scan_ctrl #(.SETTLE(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .continuous(cont1), .ovr_clr(ovr_clr1),
      .bus(if1.master), .busy(busy1), .overrun(overrun1)
   );
   mux_16to1 u_mux1 (.in(in1), .sel(if1.sel), .out(if1.mux_out));

   mux_scan_ctrl #(.SETTLE(3)) u_dut3 (
      .clk(clk), .rst(rst), .start(start3), .continuous(cont3), .ovr_clr(ovr_clr3),
      .bus(if3.master), .busy(busy3), .overrun(overrun3)
   );
   mux_16to1 u_mux3 (.in(in3), .sel(if3.sel), .out(if3.mux_out));

   always #5 clk = ~clk;

   always @(posedge clk) rdy_edge <= if1.frame_ready;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Frame monitor: a new frame appears when valid rises or is reloaded on a transfer edge
   initial begin
      exp_t e;
      logic fv;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         fv = if1.frame_valid;
         if (fv && (!fv_prev || rdy_edge)) begin
            frames_seen++;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_frame: got 0x%0h expected none (cycle %0d)", if1.frame, cyc);
            end else begin
               e = sb.pop_front();
               check("frame_value", 32'(if1.frame), 32'(e.frame));
               check("frame_cycle", 32'(cyc), 32'(e.cyc));
            end
         end
         fv_prev = fv;
      end
   end

   task automatic start_scan1(input logic [15:0] val, input logic [15:0] exp,
                              input logic cont, output int k);
      exp_t e;
      @(negedge clk);
      in1    = val;
      cont1  = cont;
      start1 = 1'b1;
      k      = cyc + 1;
      e.frame = exp;
      e.cyc   = k + 32;
      sb.push_back(e);
      @(negedge clk);
      start1 = 1'b0;
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic wait_frames(input int target);
      for (int n = 0; n < 200 && frames_seen < target; n++) @(negedge clk);
      check("frame_wait", 32'(frames_seen >= target), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_sel"},     32'(if1.sel),         32'd0);
      check({tag, "_frame"},   32'(if1.frame),       32'd0);
      check({tag, "_fv"},      32'(if1.frame_valid), 32'd0);
      check({tag, "_busy"},    32'(busy1),           32'd0);
      check({tag, "_overrun"}, 32'(overrun1),        32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vecs[6];
      exp_t e;
      int   k;
      int   base;
      int   exp_sel;

      vecs[0] = '{16'hA5C3, 16'hA5C3};
      vecs[1] = '{16'h0000, 16'h0000};
      vecs[2] = '{16'hFFFF, 16'hFFFF};
      vecs[3] = '{16'h0001, 16'h0001};
      vecs[4] = '{16'h8000, 16'h8000};
      vecs[5] = '{16'h1234, 16'h1234};

      if1.frame_ready = 1'b1;
      if3.frame_ready = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      check("reset_sel3", 32'(if3.sel), 32'd0);
      check("reset_busy3", 32'(busy3), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Single-shot table, SETTLE=1
      for (int i = 0; i < 6; i++) begin
         base = frames_seen;
         start_scan1(vecs[i].mux_in, vecs[i].exp_frame, 1'b0, k);
         check("busy_after_start", 32'(busy1), 32'd1);
         wait_frames(base + 1);
         check("fv_at_complete", 32'(if1.frame_valid), 32'd1);
         check("busy_after_complete", 32'(busy1), 32'd0);
         @(negedge clk);
         check("fv_drop", 32'(if1.frame_valid), 32'd0);
         check("overrun_clear", 32'(overrun1), 32'd0);
      end

      // SETTLE=3: each select held 4 cycles, frame at k+64
      @(negedge clk);
      in3    = 16'h8001;
      start3 = 1'b1;
      @(negedge clk);
      start3 = 1'b0;
      for (int j = 0; j <= 64; j++) begin
         exp_sel = (j / 4 > 15) ? 15 : j / 4;
         check("sel3_step", 32'(if3.sel), 32'(exp_sel));
         check("busy3_step", 32'(busy3), 32'(j < 64));
         check("fv3_step", 32'(if3.frame_valid), 32'(j == 64));
         if (j == 64) check("frame3", 32'(if3.frame), 32'h8001);
         if (j < 64) @(negedge clk);
      end
      @(negedge clk);
      check("fv3_drop", 32'(if3.frame_valid), 32'd0);

      // Continuous, back-to-back frames 32 cycles apart, stop after second
      base = frames_seen;
      start_scan1(16'h00FF, 16'h00FF, 1'b1, k);
      wait_frames(base + 1);
      in1 = 16'hFF00;
      cont1 = 1'b0;
      e.frame = 16'hFF00;
      e.cyc   = k + 64;
      sb.push_back(e);
      check("cont_busy_between", 32'(busy1), 32'd1);
      wait_frames(base + 2);
      check("cont_busy_end", 32'(busy1), 32'd0);

      // Continuous with downstream stalled: hold, overrun, clear, coincident accept
      @(negedge clk);
      if1.frame_ready = 1'b0;
      base = frames_seen;
      start_scan1(16'h1234, 16'h1234, 1'b1, k);
      wait_frames(base + 1);
      wait_until(k + 63);
      check("ovr_before_drop", 32'(overrun1), 32'd0);
      wait_until(k + 64);
      check("ovr_set", 32'(overrun1), 32'd1);
      check("frame_held", 32'(if1.frame), 32'h1234);
      check("fv_held", 32'(if1.frame_valid), 32'd1);
      in1 = 16'h4321;
      e.frame = 16'h4321;
      e.cyc   = k + 96;
      sb.push_back(e);
      ovr_clr1 = 1'b1;
      @(negedge clk);
      ovr_clr1 = 1'b0;
      check("ovr_cleared", 32'(overrun1), 32'd0);
      wait_until(k + 95);
      if1.frame_ready = 1'b1;
      cont1 = 1'b0;
      wait_frames(base + 2);
      check("ovr_coincident", 32'(overrun1), 32'd0);
      check("busy_after_cont", 32'(busy1), 32'd0);
      @(negedge clk);
      check("fv_drop_cont", 32'(if1.frame_valid), 32'd0);

      // Reset at channel 7, then a full clean frame
      base = frames_seen;
      start_scan1(16'h5A5A, 16'h5A5A, 1'b0, k);
      wait_until(k + 15);
      check("sel_ch7", 32'(if1.sel), 32'd7);
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      check("no_resume_busy", 32'(busy1), 32'd0);
      check("no_resume_frame", 32'(frames_seen), 32'(base));
      start_scan1(16'h5A5A, 16'h5A5A, 1'b0, k);
      wait_frames(base + 1);

      // start re-pulsed while busy is ignored
      base = frames_seen;
      start_scan1(16'hC3A5, 16'hC3A5, 1'b0, k);
      wait_until(k + 10);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      wait_until(k + 31);
      start1 = 1'b1;
      wait_frames(base + 1);
      start1 = 1'b0;
      check("repulse_busy", 32'(busy1), 32'd0);
      @(negedge clk);
      check("repulse_idle", 32'(busy1), 32'd0);
      check("repulse_sel", 32'(if1.sel), 32'd15);

      repeat (5) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequencing stage that sits directly upstream of `mux_16to1`. It drives that mux's `sel` through channels 0..15, waits a programmable settle time, samples the mux `out` bit for each channel, and assembles the 16 samples into one frame word. Each frame is presented downstream on a valid/ready handshake. The block supports single-shot and continuous scanning, with overrun detection.

## Interface
Parameters:
- `NUM_CH`, 16: channels per frame; equals the mux input width.
- `SEL_W`, 4: select width, clog2(`NUM_CH`).
- `SETTLE`, 1: cycles `sel` is held before the sample cycle; legal range 1..255.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  scan request; sampled only in IDLE.
- `continuous`  in  1  when 1, a new scan begins immediately after each frame completes.
- `ovr_clr`  in  1  clears `overrun`.
- `mux_out`  in  1  the mux `out` bit.
- `sel`  out  `SEL_W`  mux select.
- `frame`  out  `NUM_CH`  completed frame; bit i is the channel-i sample.
- `frame_valid`  out  1  `frame` holds an unconsumed frame.
- `frame_ready`  in  1  downstream accepts `frame`.
- `busy`  out  1  a scan is in progress (state is not IDLE).
- `overrun`  out  1  sticky flag: a completed frame was dropped.

## Operation
- FSM states: IDLE, SETTLE, SAMPLE.
- **IDLE**
  - If `start`=1 at an edge: go to SETTLE, set `sel`=0, load the settle counter with `SETTLE`-1, clear the accumulator.
- **SETTLE**
  - Decrement the counter each cycle.
  - When the counter is 0 at an edge, go to SAMPLE.
- **SAMPLE** (exactly one cycle). At the exit edge:
  - Write `acc[sel]` ← `mux_out`.
  - If `sel` < `NUM_CH`-1: increment `sel`, reload the counter, go to SETTLE.
  - If `sel` = `NUM_CH`-1: frame completion (rules below). Then:
    - if `continuous`=1, set `sel`=0, reload, go to SETTLE;
    - otherwise go to IDLE with `sel` held at `NUM_CH`-1.
- **Frame completion**. At the completion edge:
  - If `frame_valid`=0, or `frame_ready`=1 (simultaneous accept): load `frame` with the accumulator including the final bit, and set `frame_valid`=1.
  - If `frame_valid`=1 and `frame_ready`=0: keep the old frame, discard the new one, set `overrun`=1.
- **Handshake**
  - A transfer occurs at any edge where `frame_valid` and `frame_ready` are both 1.
  - On transfer with no completion at the same edge, `frame_valid` goes to 0.
  - `frame` is stable while `frame_valid`=1.
- `start` while `busy` is ignored.
- Deasserting `continuous` mid-scan: the current frame finishes, then the FSM returns to IDLE.
- `overrun` stays set until an edge with `ovr_clr`=1. If a new drop occurs at that same edge, set wins.
- `sel` changes only on a SAMPLE exit edge or an IDLE→SETTLE edge. It never changes during SETTLE.

## Timing
- All outputs reset to 0: `sel`=0, `frame`=0, `frame_valid`=0, `busy`=0, `overrun`=0. State resets to IDLE and the accumulator to 0.
- `rst` mid-scan: the partial frame is lost and the reset values above apply immediately (asynchronous). The scan does not resume after reset.
- Per-channel cost is `SETTLE`+1 cycles.
- Channel i is captured at edge k+(i+1)(`SETTLE`+1), where edge k is the edge that sampled `start`.
- `frame_valid` rises at edge k+`NUM_CH`(`SETTLE`+1); this is 32 cycles at the defaults.
- In continuous mode, back-to-back frames are exactly `NUM_CH`(`SETTLE`+1) cycles apart, with no dead cycle.
- `busy` is 1 from edge k up to the completion edge of a non-continuous scan.

## Structure
- Package `mux_scan_pkg` holds:
  - localparams `NUM_CH`=16 and `SEL_W`=4;
  - a `SETTLE_W`=8 counter width;
  - the state enum `scan_state_t` {IDLE, SETTLE, SAMPLE}.
- Single module, no sub-module. The settle counter and FSM are inline.
- `mux_16to1` is instantiated alongside this block by the parent, not inside it.
- The bench connects `sel` and `mux_out` through a real `mux_16to1`.

## Test plan
- Single shot, `SETTLE`=1, mux `in`=16'hA5C3, `start` pulse at edge k, `frame_ready`=1:
  - `frame_valid` rises at k+32 with `frame`=16'hA5C3;
  - it drops the next cycle;
  - `busy` is 0 after the completion edge.
- `SETTLE`=3, `in`=16'h8001: each `sel` value is held 4 cycles, `frame`=16'h8001 at k+64, and `sel` never skips or repeats.
- Continuous mode, `frame_ready`=1, `in` changed from 16'h00FF to 16'hFF00 between frames: frames 16'h00FF then 16'hFF00, exactly 32 cycles apart.
- Continuous mode, `frame_ready`=0:
  - first frame held;
  - second completion sets `overrun` with `frame` unchanged;
  - `ovr_clr` clears `overrun`;
  - `frame_ready`=1 coincident with the completion edge gives the new frame with no overrun.
- `rst` pulsed at channel 7 mid-scan: all outputs are 0 immediately, state returns to IDLE, and a later `start` produces a full, correct frame.
- `start` re-pulsed while `busy`: ignored, and the frame timing is unchanged.
